// File: rtl/ram_pipe.sv
// ram_pipe: single-port word RAM with byte-lane write strobes, a
// request/response handshake and a READ_LATENCY-deep response pipeline.
//
// Optional build macro: RAM_BOUNDS_CHECK_EN
//   defined   -> any address bit above the word-index field marks the request
//                out of range: the write is dropped, a read returns 0, and the
//                response carries rsp_err_o=1 with unchanged timing.
//   undefined -> upper address bits are ignored (wraps modulo DEPTH words)
//                and rsp_err_o stays 0.
//
// Stage 0 of the pipeline is the registered RAM read itself. Stages
// 1..READ_LATENCY-1 are plain shift registers. Every stage holds while the
// consumer stalls the last stage.
module ram_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    req_ready_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic                    rsp_err_o
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int IDX   = $clog2(DEPTH);

    logic           stall;
    logic           accept;
    logic           in_range;
    logic           do_write;
    logic           do_read;
    logic [IDX-1:0] word_idx;
    logic           unused_addr;

    // Flattened per-stage chains; each stage drives its own slice.
    wire [READ_LATENCY-1:0]            valid_chain;
    wire [READ_LATENCY-1:0]            err_chain;
    wire [READ_LATENCY*DATA_WIDTH-1:0] data_chain;

    // The last stage is the only one that can be refused by the consumer;
    // a refused response freezes the whole pipe and blocks new requests.
    assign stall       = rsp_valid_o & ~rsp_ready_i;
    assign req_ready_o = ~rst_i & ~stall;
    assign accept      = req_i & req_ready_o;
    assign word_idx    = addr_i[OFF+IDX-1:OFF];

    // Low byte-offset bits (and, without the range check, the upper bits)
    // do not take part in addressing.
    assign unused_addr = ^addr_i;

`ifdef RAM_BOUNDS_CHECK_EN
    generate
        if (ADDR_WIDTH > OFF + IDX) begin : g_bounds
            assign in_range = ~|addr_i[ADDR_WIDTH-1:OFF+IDX];
        end else begin : g_no_bounds
            assign in_range = 1'b1;
        end
    endgenerate
`else
    assign in_range = 1'b1;
`endif

    // Out-of-range requests still produce a response, they just never touch
    // the array.
    assign do_write = accept &  we_i & in_range;
    assign do_read  = accept & ~we_i & in_range;

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane, so each strobe is a plain
    // per-lane write enable. The lane read register doubles as the stage-0
    // data register and is cleared for writes and bubbles, which makes
    // write responses and idle outputs read as zero.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rd_reg;

            // Byte-lane write on an accepted, in-range write with its strobe set.
            always_ff @(posedge clk_i) begin
                if (do_write && be_i[gi]) begin
                    mem_lane[word_idx] <= data_i[gi*8 +: 8];
                end
            end

            // Synchronous read sampled at the accept edge; holds during a stall.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rd_reg <= 8'h00;
                end else if (!stall) begin
                    rd_reg <= do_read ? mem_lane[word_idx] : 8'h00;
                end
            end

            assign data_chain[gi*8 +: 8] = rd_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 0 control bits: valid for every accepted request, error for an
    // accepted request that fell outside the array.
    // ------------------------------------------------------------------
    logic stage0_valid_reg;
    logic stage0_err_reg;

    // Stage-0 valid/err capture; a non-accepting, non-stalled edge inserts a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage0_valid_reg <= 1'b0;
            stage0_err_reg   <= 1'b0;
        end else if (!stall) begin
            stage0_valid_reg <= accept;
            stage0_err_reg   <= accept & ~in_range;
        end
    end

    assign valid_chain[0] = stage0_valid_reg;
    assign err_chain[0]   = stage0_err_reg;

    // ------------------------------------------------------------------
    // Delay stages 1..READ_LATENCY-1. With READ_LATENCY=1 this loop is
    // empty and stage 0 drives the response directly.
    // ------------------------------------------------------------------
    generate
        for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
            logic                  valid_reg;
            logic                  err_reg;
            logic [DATA_WIDTH-1:0] data_reg;

            // Shift one step per non-stalled edge; reset drops in-flight responses.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    data_reg  <= '0;
                end else if (!stall) begin
                    valid_reg <= valid_chain[gi-1];
                    err_reg   <= err_chain[gi-1];
                    data_reg  <= data_chain[(gi-1)*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            assign valid_chain[gi]                          = valid_reg;
            assign err_chain[gi]                            = err_reg;
            assign data_chain[gi*DATA_WIDTH +: DATA_WIDTH]  = data_reg;
        end
    endgenerate

    assign rsp_valid_o = valid_chain[READ_LATENCY-1];
    assign rsp_data_o  = data_chain[(READ_LATENCY-1)*DATA_WIDTH +: DATA_WIDTH];

    // Without the range check in_range is constant 1, so the error chain is
    // constant 0 as well.
    assign rsp_err_o   = err_chain[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_pipe.sv
// tb_ram_pipe: scoreboard bench for ram_pipe. Three instances cover
// READ_LATENCY 1/3/4; stimulus pushes the hand-computed response into a
// queue and a negedge monitor pops and compares every accepted response.
module tb_ram_pipe;

    localparam int NDUT = 3;
    localparam int LAT_TAB   [NDUT] = '{1, 3, 4};
    localparam int DEPTH_TAB [NDUT] = '{16, 64, 64};

`ifdef RAM_BOUNDS_CHECK_EN
    localparam logic [31:0] OOR_RD_DATA  = 32'h0000_0000;
    localparam logic        OOR_ERR      = 1'b1;
    localparam logic [31:0] WORD0_AFTER  = 32'h5566_7788;
`else
    localparam logic [31:0] OOR_RD_DATA  = 32'hCAFE_F00D;
    localparam logic        OOR_ERR      = 1'b0;
    localparam logic [31:0] WORD0_AFTER  = 32'hCAFE_F00D;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req       [NDUT];
    logic        we        [NDUT];
    logic        rsp_ready [NDUT];
    logic [3:0]  be        [NDUT];
    logic [31:0] addr      [NDUT];
    logic [31:0] wdata     [NDUT];
    logic        rdy       [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_err   [NDUT];
    logic [31:0] rsp_data  [NDUT];

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            ram_pipe #(
                .DATA_WIDTH   (32),
                .ADDR_WIDTH   (32),
                .DEPTH        (DEPTH_TAB[gi]),
                .READ_LATENCY (LAT_TAB[gi])
            ) u_dut (
                .clk_i       (clk),
                .rst_i       (rst),
                .req_i       (req[gi]),
                .req_ready_o (rdy[gi]),
                .we_i        (we[gi]),
                .be_i        (be[gi]),
                .addr_i      (addr[gi]),
                .data_i      (wdata[gi]),
                .rsp_valid_o (rsp_valid[gi]),
                .rsp_ready_i (rsp_ready[gi]),
                .rsp_data_o  (rsp_data[gi]),
                .rsp_err_o   (rsp_err[gi])
            );
        end
    endgenerate

    // Monitor: every response transferred at the coming edge is checked
    // against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (rsp_valid[d] && rsp_ready[d]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected dut%0d: got data=%h err=%b, required no response",
                             d, rsp_data[d], rsp_err[d]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.dut != d || rsp_data[d] !== e.data || rsp_err[d] !== e.err) begin
                        errors++;
                        $display("FAIL rsp_compare dut%0d: got data=%h err=%b, required dut%0d data=%h err=%b",
                                 d, rsp_data[d], rsp_err[d], e.dut, e.data, e.err);
                    end else begin
                        $display("rsp dut%0d data=%h err=%b ok", d, rsp_data[d], rsp_err[d]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req_v);
        end
    endtask

    // Issue one request on instance d and push its expected response when accepted.
    task automatic issue(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        exp_t e;
        int   n    = 0;
        bit   done = 0;
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        while (!done) begin
            @(negedge clk);
            if (rdy[d]) begin
                @(posedge clk);
                e.dut = d; e.data = ed; e.err = ee;
                exp_q.push_back(e);
                #1;
                req[d] = 1'b0;
                done = 1;
            end else begin
                n++;
                if (n >= 50) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_timeout dut%0d addr=%h: got no accept in %0d cycles, required accept", d, a, n);
                    @(posedge clk);
                    #1;
                    req[d] = 1'b0;
                    done = 1;
                end
            end
        end
    endtask

    // Wait (bounded) until every expected response has been observed.
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Hold reset for several edges, optionally with a write request asserted on dut0.
    task automatic do_reset(input bit drive_req);
        rst = 1'b1;
        if (drive_req) begin
            req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'h0BAD_F00D;
        end
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("rst_req_ready_dut%0d", d), {31'b0, rdy[d]}, 32'h0);
                chk($sformatf("rst_rsp_valid_dut%0d", d), {31'b0, rsp_valid[d]}, 32'h0);
                chk($sformatf("rst_rsp_data_dut%0d", d), rsp_data[d], 32'h0);
                chk($sformatf("rst_rsp_err_dut%0d", d), {31'b0, rsp_err[d]}, 32'h0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req[0] = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        int          n;
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = '0; wdata[d] = '0;
            rsp_ready[d] = 1'b1;
        end
        do_reset(1'b0);

        // LAT=1: write then read of the same word on consecutive accepts.
        issue(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);
        drain();

        // Reset with a write pending must not touch memory nor emit a response.
        do_reset(1'b1);
        issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte-lane strobes, then an all-zero strobe write.
        issue(0, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD, 32'h0, 1'b0);
        issue(0, 1'b1, 4'h5, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        issue(0, 1'b0, 4'h0, 32'h20, 32'h0,         32'hAA22_CC44, 1'b0);
        issue(0, 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b0);
        issue(0, 1'b0, 4'hF, 32'h20, 32'h0,         32'hAA22_CC44, 1'b0);

        // DEPTH=16: address 0x40 lies just beyond the array.
        issue(0, 1'b1, 4'hF, 32'h00, 32'h5566_7788, 32'h0, 1'b0);
        issue(0, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D, 32'h0, OOR_ERR);
        issue(0, 1'b0, 4'hF, 32'h40, 32'h0,         OOR_RD_DATA, OOR_ERR);
        issue(0, 1'b0, 4'hF, 32'h00, 32'h0,         WORD0_AFTER, 1'b0);
        drain();

        // LAT=3: preload 8 words, then stream 8 reads with a 2-cycle consumer stall.
        for (int i = 0; i < 8; i++) begin
            issue(1, 1'b1, 4'hF, 32'(i * 4), 32'hA500_0000 | 32'(i * 17), 32'h0, 1'b0);
        end
        drain();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    issue(1, 1'b0, 4'hF, 32'(i * 4), 32'h0, 32'hA500_0000 | 32'(i * 17), 1'b0);
                end
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!rsp_valid[1] && n < 100);
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1;
                rsp_ready[1] = 1'b0;
                @(negedge clk);
                held = rsp_data[1];
                chk("stall_rsp_valid_1", {31'b0, rsp_valid[1]}, 32'h1);
                chk("stall_req_ready_1", {31'b0, rdy[1]}, 32'h0);
                @(negedge clk);
                chk("stall_rsp_valid_2", {31'b0, rsp_valid[1]}, 32'h1);
                chk("stall_req_ready_2", {31'b0, rdy[1]}, 32'h0);
                chk("stall_rsp_data_hold", rsp_data[1], held);
                @(posedge clk);
                #1;
                rsp_ready[1] = 1'b1;
            end
        join
        drain();

        // LAT=4: a read in flight is not disturbed by the following write.
        issue(2, 1'b1, 4'hF, 32'h40, 32'h0A0A_0A0A, 32'h0, 1'b0);
        drain();
        issue(2, 1'b0, 4'hF, 32'h40, 32'h0,         32'h0A0A_0A0A, 1'b0);
        issue(2, 1'b1, 4'hF, 32'h40, 32'h0B0B_0B0B, 32'h0, 1'b0);
        issue(2, 1'b0, 4'hF, 32'h40, 32'h0,         32'h0B0B_0B0B, 1'b0);
        drain();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
